// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master, slave and transmit queue:
// the handshake FSM state encoding and the default data word width.
package spi_pkg;

  localparam int SPI_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_fifo.sv
// Circular word FIFO feeding the SPI handshake FSM. The read port is
// combinational so the popped word is available in the cycle of the pop.
module spi_fifo import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             overflow_reg;
  logic             push;
  logic             pop;

  assign full  = (level_reg == LW'(DEPTH));
  assign empty = (level_reg == '0);
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write to a full queue still lands.
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= wr_en && !push;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data  = mem[rd_ptr_reg];
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/spi_tx_queue.sv
// Transmit queue in front of an SPI master: buffers words and hands them
// over one at a time with a newd/cs handshake and an enforced idle gap.
module spi_tx_queue import spi_pkg::*; #(
  parameter int WIDTH   = SPI_WIDTH,
  parameter int DEPTH   = 8,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   m_cs,
  output logic                   m_newd,
  output logic [WIDTH-1:0]       m_din,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  spi_state_t     state_reg, state_next;
  logic           cs_meta_reg, cs_s_reg;
  logic [TW-1:0]  wait_reg, wait_next;
  logic [GW-1:0]  gap_reg, gap_next;
  logic           err_reg, err_next;
  logic [WIDTH-1:0] din_reg;
  logic [WIDTH-1:0] fifo_rd_data;
  logic           pop;

  spi_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // m_cs toggles relative to sclk, not clk, so it is resynchronized before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_reg <= 1'b1;
      cs_s_reg    <= 1'b1;
    end else begin
      cs_meta_reg <= m_cs;
      cs_s_reg    <= cs_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      wait_reg  <= '0;
      gap_reg   <= '0;
      err_reg   <= 1'b0;
      din_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      gap_reg   <= gap_next;
      err_reg   <= err_next;
      if (pop) begin
        din_reg <= fifo_rd_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    gap_next   = gap_reg;
    err_next   = err_reg;
    pop        = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (!empty && cs_s_reg) begin
          state_next = ST_REQ;
          pop        = 1'b1;
          wait_next  = '0;
        end
      end
      ST_REQ: begin
        // Counter saturates one short of TIMEOUT; the flag is sticky.
        if (wait_reg == TW'(TIMEOUT - 1)) begin
          err_next = 1'b1;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
        if (!cs_s_reg) begin
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (cs_s_reg) begin
          state_next = ST_GAP;
          gap_next   = '0;
        end
      end
      ST_GAP: begin
        if (gap_reg == GW'(GAP - 1)) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign m_newd      = (state_reg == ST_REQ);
  assign busy        = (state_reg != ST_IDLE);
  assign m_din       = din_reg;
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue: a vector table of single-word transfers
// plus hand-written sequences for overflow, timeout, reset and streaming.
module tb_spi_tx_queue;

  localparam int WIDTH   = 12;
  localparam int DEPTH   = 8;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [3:0]       level;
  logic             overflow;
  logic             m_cs;
  logic             m_newd;
  logic [WIDTH-1:0] m_din;
  logic             busy;
  logic             timeout_err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  spi_tx_queue #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .m_cs        (m_cs),
    .m_newd      (m_newd),
    .m_din       (m_din),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] wdata;
    logic [11:0] exp_din;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy; n++) tick();
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic finish_xfer();
    m_cs = 1'b0;
    repeat (4) tick();
    m_cs = 1'b1;
    wait_idle();
  endtask

  // Master + slave model: the slave's received word is whatever m_din held at newd.
  task automatic do_transfer(output logic [11:0] d);
    for (int n = 0; n < 200 && !m_newd; n++) tick();
    check("newd_wait", 32'(m_newd), 32'd1);
    d = m_din;
    finish_xfer();
  endtask

  initial begin
    logic [11:0] got;
    logic [11:0] exp_q[$];
    int newd_seen;

    vecs[0] = '{wdata: 12'hA5C, exp_din: 12'hA5C};
    vecs[1] = '{wdata: 12'h000, exp_din: 12'h000};
    vecs[2] = '{wdata: 12'hFFF, exp_din: 12'hFFF};
    vecs[3] = '{wdata: 12'h800, exp_din: 12'h800};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; m_cs = 1'b1;
    repeat (3) tick();
    check("rst_empty",   32'(empty), 32'd1);
    check("rst_full",    32'(full), 32'd0);
    check("rst_level",   32'(level), 32'd0);
    check("rst_newd",    32'(m_newd), 32'd0);
    check("rst_din",     32'(m_din), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_ovf",     32'(overflow), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single-word handshake per table entry.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = vecs[i].wdata;
      tick();
      wr_en = 1'b0;
      check("t_newd_lat1", 32'(m_newd), 32'd0);
      check("t_level1",    32'(level), 32'd1);
      tick();
      check("t_newd_lat2", 32'(m_newd), 32'd1);
      check("t_din",       32'(m_din), 32'(vecs[i].exp_din));
      check("t_empty_pop", 32'(empty), 32'd1);
      repeat (3) tick();
      check("t_din_hold",  32'(m_din), 32'(vecs[i].exp_din));
      m_cs = 1'b0;
      repeat (2) tick();
      check("t_newd_sync", 32'(m_newd), 32'd1);
      tick();
      check("t_newd_low",  32'(m_newd), 32'd0);
      check("t_busy_xfer", 32'(busy), 32'd1);
      tick();
      m_cs = 1'b1;
      repeat (GAP + 2) tick();
      check("t_busy_gap",  32'(busy), 32'd1);
      tick();
      check("t_busy_idle", 32'(busy), 32'd0);
      check("t_din_after", 32'(m_din), 32'(vecs[i].exp_din));
    end

    // Ten back-to-back writes with the master stalled: one popped, eight queued, one dropped.
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 12'h100 + 12'(i);
      tick();
      if (i == 8) begin
        check("ovf_full8",  32'(full), 32'd1);
        check("ovf_none8",  32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_full",  32'(full), 32'd1);
    check("ovf_din",   32'(m_din), 32'h100);
    tick();
    check("ovf_clear", 32'(overflow), 32'd0);

    // Pop and write in the same cycle on a full queue.
    finish_xfer();
    wr_en = 1'b1; wr_data = 12'h10A;
    tick();
    wr_en = 1'b0;
    check("pw_level", 32'(level), 32'd8);
    check("pw_full",  32'(full), 32'd1);
    check("pw_ovf",   32'(overflow), 32'd0);
    check("pw_din",   32'(m_din), 32'h101);
    check("pw_newd",  32'(m_newd), 32'd1);

    // Stay in REQ with cs high until the timeout fires.
    repeat (TIMEOUT - 1) tick();
    check("to_before", 32'(timeout_err), 32'd0);
    tick();
    check("to_set",    32'(timeout_err), 32'd1);

    exp_q = '{12'h101, 12'h102, 12'h103, 12'h104, 12'h105, 12'h106, 12'h107, 12'h108, 12'h10A};
    foreach (exp_q[k]) begin
      do_transfer(got);
      check("drain_word", 32'(got), 32'(exp_q[k]));
    end
    check("drain_empty",  32'(empty), 32'd1);
    check("to_sticky",    32'(timeout_err), 32'd1);

    // Reset while in XFER with three words queued.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 12'h201 + 12'(i);
      tick();
    end
    wr_en = 1'b0;
    check("rx_level3", 32'(level), 32'd3);
    m_cs = 1'b0;
    repeat (4) tick();
    check("rx_in_xfer", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rx_level",   32'(level), 32'd0);
    check("rx_empty",   32'(empty), 32'd1);
    check("rx_newd",    32'(m_newd), 32'd0);
    check("rx_din",     32'(m_din), 32'd0);
    check("rx_busy",    32'(busy), 32'd0);
    check("rx_timeout", 32'(timeout_err), 32'd0);
    tick();
    rst = 1'b0;
    m_cs = 1'b1;
    newd_seen = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (m_newd) newd_seen++;
    end
    check("rx_no_newd", 32'(newd_seen), 32'd0);

    // Stream 001..005 twice so both pointers wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        wr_en = 1'b1; wr_data = 12'h001 + 12'(i);
        tick();
      end
      wr_en = 1'b0;
      exp_q = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
      foreach (exp_q[k]) begin
        do_transfer(got);
        check("stream_word", 32'(got), 32'(exp_q[k]));
      end
      check("stream_level", 32'(level), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
